// File: rtl/edge_pulse_meter.sv
// edge_pulse_meter: measures high-pulse widths (pos_edge to the following neg_edge)
// in clk cycles and queues {sat, width} results in a small first-word fall-through
// FIFO drained over a valid/ready stream.
// Optional feature macro: EDGE_METER_GLITCH_EN. When it is defined, pulses narrower
// than MIN_WIDTH are discarded and counted on glitch_cnt.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a rising edge; a lone falling edge is ignored
// MEAS  | line is high, cnt holds cycles elapsed since the rising edge
module edge_pulse_meter #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_WIDTH  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pos_edge_i,
  input  logic             neg_edge_i,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] m_width,
  output logic             m_sat,
  output logic             busy,
`ifdef EDGE_METER_GLITCH_EN
  output logic [7:0]       glitch_cnt,
`endif
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Reject parameter values the pointer scheme and glitch filter cannot handle.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("edge_pulse_meter: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (MIN_WIDTH < 0) begin : g_minw_chk
    $error("edge_pulse_meter: MIN_WIDTH must be non-negative");
  end

  typedef enum logic {IDLE, MEAS} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             meas_done;
  logic             push_req;

  logic [CNT_W:0]   mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic             do_pop, do_push;
  logic [CNT_W:0]   head;

  // Measurement state, counter and saturation flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  // Next-state logic: start, restart, count with saturation, and completion.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    meas_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (pos_edge_i) begin
          state_d = MEAS;
          cnt_d   = CNT_ONE;
          sat_d   = 1'b0;
        end
      end
      MEAS: begin
        if (neg_edge_i) begin
          meas_done = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
          sat_d     = 1'b0;
        end else if (pos_edge_i) begin
          // A missed falling edge: the new rising edge starts a fresh pulse.
          cnt_d = CNT_ONE;
          sat_d = 1'b0;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
          sat_d = sat_q | (cnt_d == CNT_MAX);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sat_d   = 1'b0;
      end
    endcase
  end

  assign busy = (state_q == MEAS);

`ifdef EDGE_METER_GLITCH_EN
  localparam logic [31:0] MIN_W32 = MIN_WIDTH;
  logic glitch;

  assign glitch   = meas_done && (32'(cnt_q) < MIN_W32);
  assign push_req = meas_done && !glitch;

  // Saturating count of pulses discarded as too narrow.
  always_ff @(posedge clk) begin
    if (rst)                             glitch_cnt <= 8'd0;
    else if (glitch && glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 8'd1;
  end
`else
  assign push_req = meas_done;
`endif

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop     = m_valid && m_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push    = push_req && (!fifo_full || do_pop);

  // FIFO pointers and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push_req && fifo_full && !do_pop) overflow <= 1'b1;
    end
  end

  // Result storage; contents are only visible through the empty-gated head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= {sat_q, cnt_q};
  end

  assign head    = mem[rd_ptr[AW-1:0]];
  assign m_valid = !fifo_empty;
  assign m_width = fifo_empty ? '0   : head[CNT_W-1:0];
  assign m_sat   = fifo_empty ? 1'b0 : head[CNT_W];

endmodule

// File: tb/tb_edge_pulse_meter.sv
// tb_edge_pulse_meter: scoreboard bench for edge_pulse_meter. Two instances share
// stimulus: a 16-bit counter and a 4-bit counter for saturation behaviour.
// Honours EDGE_METER_GLITCH_EN the same way the design does.
module tb_edge_pulse_meter;

  localparam int DEPTH = 4;
  localparam int MINW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pos_edge_i = 1'b0;
  logic neg_edge_i = 1'b0;
  logic m_ready = 1'b1;

  logic        v16, s16, busy16, ovf16;
  logic [15:0] w16;
  logic        v4, s4, busy4, ovf4;
  logic [3:0]  w4;
`ifdef EDGE_METER_GLITCH_EN
  logic [7:0]  g16, g4;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [16:0] sb16[$];
  logic [4:0]  sb4[$];
  logic        exp_ovf = 1'b0;
  int          exp_glitch = 0;

  edge_pulse_meter #(.CNT_W(16), .FIFO_DEPTH(DEPTH), .MIN_WIDTH(MINW)) dut16 (
    .clk(clk), .rst(rst), .pos_edge_i(pos_edge_i), .neg_edge_i(neg_edge_i),
    .m_valid(v16), .m_ready(m_ready), .m_width(w16), .m_sat(s16), .busy(busy16),
`ifdef EDGE_METER_GLITCH_EN
    .glitch_cnt(g16),
`endif
    .overflow(ovf16)
  );

  edge_pulse_meter #(.CNT_W(4), .FIFO_DEPTH(DEPTH), .MIN_WIDTH(MINW)) dut4 (
    .clk(clk), .rst(rst), .pos_edge_i(pos_edge_i), .neg_edge_i(neg_edge_i),
    .m_valid(v4), .m_ready(m_ready), .m_width(w4), .m_sat(s4), .busy(busy4),
`ifdef EDGE_METER_GLITCH_EN
    .glitch_cnt(g4),
`endif
    .overflow(ovf4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Record what a completed pulse of width w should produce.
  task automatic push_exp(input int w);
    logic [16:0] e16;
    logic [4:0]  e4;
`ifdef EDGE_METER_GLITCH_EN
    if (w < MINW) begin
      if (exp_glitch < 255) exp_glitch++;
      return;
    end
`endif
    e16 = {1'b0, 16'(w)};
    e4  = (w >= 15) ? 5'h1F : {1'b0, 4'(w)};
    if (sb16.size() < DEPTH || m_ready) begin
      sb16.push_back(e16);
      sb4.push_back(e4);
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  // Rising edge, then falling edge w cycles later (optionally with a coincident rising edge).
  task automatic pulse(input int w, input bit both);
    pos_edge_i = 1'b1;
    tick();
    pos_edge_i = 1'b0;
    repeat (w - 1) tick();
    push_exp(w);
    neg_edge_i = 1'b1;
    if (both) pos_edge_i = 1'b1;
    tick();
    neg_edge_i = 1'b0;
    pos_edge_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb16.delete();
    sb4.delete();
    exp_ovf = 1'b0;
    exp_glitch = 0;
  endtask

  task automatic drain_check(input string tag);
    repeat (8) tick();
    chk({tag, "_sb16_left"}, sb16.size(), 0);
    chk({tag, "_sb4_left"}, sb4.size(), 0);
    chk({tag, "_valid_idle"}, v16, 0);
  endtask

  // Scoreboard compare for the 16-bit instance on every accepted head.
  always @(negedge clk) begin : mon16
    logic [16:0] e;
    if (!rst && m_ready && v16) begin
      if (sb16.size() == 0) chk("d16_pop_expected", sb16.size(), 1);
      else begin
        e = sb16.pop_front();
        chk("d16_width", w16, e[15:0]);
        chk("d16_sat", s16, e[16]);
      end
    end
  end

  // Scoreboard compare for the 4-bit instance on every accepted head.
  always @(negedge clk) begin : mon4
    logic [4:0] e;
    if (!rst && m_ready && v4) begin
      if (sb4.size() == 0) chk("d4_pop_expected", sb4.size(), 1);
      else begin
        e = sb4.pop_front();
        chk("d4_width", w4, e[3:0]);
        chk("d4_sat", s4, e[4]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_valid", v16, 0);
    chk("rst_width", w16, 0);
    chk("rst_sat", s16, 0);
    chk("rst_busy", busy16, 0);
    chk("rst_ovf", ovf16, 0);
`ifdef EDGE_METER_GLITCH_EN
    chk("rst_glitch", g16, 0);
`endif

    // T1: width 5, busy through the pulse, valid for exactly one cycle
    m_ready = 1'b1;
    pos_edge_i = 1'b1;
    tick();
    pos_edge_i = 1'b0;
    chk("t1_busy_start", busy16, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_busy_mid", busy16, 1);
    end
    push_exp(5);
    neg_edge_i = 1'b1;
    tick();
    neg_edge_i = 1'b0;
    chk("t1_busy_end", busy16, 0);
    chk("t1_valid_lat", v16, 1);
    tick();
    chk("t1_valid_once", v16, 0);
    drain_check("t1");

    // T2: saturation boundaries on the 4-bit instance
    do_reset();
    pulse(20, 1'b0);
    pulse(15, 1'b0);
    pulse(14, 1'b0);
    drain_check("t2");

    // T3: fill with m_ready low, fifth result dropped, then ordered drain
    do_reset();
    m_ready = 1'b0;
    for (int w = 3; w <= 7; w++) begin
      pulse(w, 1'b0);
      if (w == 6) chk("t3_ovf_before", ovf16, 0);
    end
    tick();
    chk("t3_ovf16", ovf16, exp_ovf);
    chk("t3_ovf4", ovf4, exp_ovf);
    chk("t3_head_hold", w16, 3);
    tick();
    chk("t3_head_stable", w16, 3);
    chk("t3_valid_hold", v16, 1);
    m_ready = 1'b1;
    drain_check("t3");
    chk("t3_ovf_sticky", ovf16, 1);

    // T4: lone neg ignored, pos restart, coincident pos/neg in IDLE and MEAS
    do_reset();
    chk("t4_ovf_cleared", ovf16, 0);
    neg_edge_i = 1'b1;
    tick();
    neg_edge_i = 1'b0;
    chk("t4_neg_alone_busy", busy16, 0);
    chk("t4_neg_alone_valid", v16, 0);
    pos_edge_i = 1'b1;
    tick();
    pos_edge_i = 1'b0;
    chk("t4_busy_first_pos", busy16, 1);
    tick();
    pulse(4, 1'b0);
    drain_check("t4a");
    pos_edge_i = 1'b1;
    neg_edge_i = 1'b1;
    tick();
    pos_edge_i = 1'b0;
    neg_edge_i = 1'b0;
    chk("t4_idle_both_busy", busy16, 1);
    repeat (2) tick();
    push_exp(3);
    neg_edge_i = 1'b1;
    tick();
    neg_edge_i = 1'b0;
    pulse(6, 1'b1);
    chk("t4_meas_both_idle", busy16, 0);
    drain_check("t4b");

    // T5: reset mid-measurement and with a queued entry
    do_reset();
    pos_edge_i = 1'b1;
    tick();
    pos_edge_i = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    neg_edge_i = 1'b1;
    tick();
    neg_edge_i = 1'b0;
    tick();
    chk("t5_busy", busy16, 0);
    chk("t5_valid", v16, 0);
    m_ready = 1'b0;
    pulse(3, 1'b0);
    chk("t5_queued", v16, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb16.delete();
    sb4.delete();
    chk("t5_flush_valid", v16, 0);
    chk("t5_flush_width", w16, 0);
    m_ready = 1'b1;
    drain_check("t5");

    // T6: widths 1 and 2 against the glitch threshold
    do_reset();
    pulse(1, 1'b0);
    pulse(2, 1'b0);
    drain_check("t6");
`ifdef EDGE_METER_GLITCH_EN
    chk("t6_glitch_cnt", g16, exp_glitch);
    chk("t6_glitch_ovf", ovf16, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
